// File: rtl/bullet_scheduler.sv
// Bullet slot scheduler: hands out the shared Bullet datapath instances to tanks.
// The grant decision uses only registered slot state and cooldowns. All grant
// pulses and slot payloads are registered.
module bullet_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_SLOTS = 2,
  parameter logic [9:0]  COOLDOWN  = 10'd30
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [NUM_REQ-1:0]      fire_req,
  input  logic [2*NUM_REQ-1:0]    req_dir,
  input  logic [10*NUM_REQ-1:0]   req_x,
  input  logic [10*NUM_REQ-1:0]   req_y,
  input  logic [NUM_SLOTS-1:0]    slot_done,
  output logic [NUM_REQ-1:0]      fire_gnt,
  output logic [NUM_SLOTS-1:0]    slot_launch,
  output logic [NUM_SLOTS-1:0]    slot_busy,
  output logic [2*NUM_SLOTS-1:0]  slot_owner,
  output logic [2*NUM_SLOTS-1:0]  slot_dir,
  output logic [10*NUM_SLOTS-1:0] slot_x,
  output logic [10*NUM_SLOTS-1:0] slot_y
);

  localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SlotW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {StFree, StLaunch, StFlight} slot_st_e;

  slot_st_e               slot_st_q [NUM_SLOTS];
  slot_st_e               slot_st_d [NUM_SLOTS];
  logic [9:0]             cool_q [NUM_REQ];
  logic [9:0]             cool_d [NUM_REQ];
  logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]     fire_gnt_q, fire_gnt_d;
  logic [NUM_SLOTS-1:0]   slot_launch_q, slot_launch_d;
  logic [2*NUM_SLOTS-1:0] slot_owner_q, slot_dir_q;
  logic [10*NUM_SLOTS-1:0] slot_x_q, slot_y_q;

  logic [NUM_REQ-1:0]     eligible;
  logic                   gnt_valid, slot_valid, do_grant;
  logic [PtrW-1:0]        gnt_idx;
  logic [SlotW-1:0]       slot_idx;

  // Eligibility, round-robin requester pick and lowest free slot pick.
  always_comb begin
    eligible   = '0;
    gnt_valid  = 1'b0;
    gnt_idx    = '0;
    slot_valid = 1'b0;
    slot_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = fire_req[i] && (cool_q[i] == 10'd0);
      // One live bullet per tank.
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (slot_st_q[s] != StFree && slot_owner_q[2*s +: 2] == 2'(i)) eligible[i] = 1'b0;
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned cand;
      cand = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_valid && eligible[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PtrW'(cand);
      end
    end
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (!slot_valid && slot_st_q[s] == StFree) begin
        slot_valid = 1'b1;
        slot_idx   = SlotW'(s);
      end
    end
    do_grant = gnt_valid && slot_valid;
  end

  // Next state for slot FSMs, cooldowns, pointer and grant pulses.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    fire_gnt_d    = '0;
    slot_launch_d = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      slot_st_d[s] = slot_st_q[s];
      case (slot_st_q[s])
        StFree:   if (do_grant && slot_idx == SlotW'(s)) slot_st_d[s] = StLaunch;
        StLaunch: slot_st_d[s] = StFlight;
        StFlight: if (slot_done[s]) slot_st_d[s] = StFree;
        default:  slot_st_d[s] = StFree;
      endcase
      slot_launch_d[s] = do_grant && (slot_idx == SlotW'(s));
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cool_d[i]     = (cool_q[i] != 10'd0) ? cool_q[i] - 10'd1 : 10'd0;
      fire_gnt_d[i] = do_grant && (gnt_idx == PtrW'(i));
      if (fire_gnt_d[i]) cool_d[i] = COOLDOWN;
    end
    if (do_grant) begin
      rr_ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PtrW'(1);
    end
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) slot_st_q[s] <= StFree;
      for (int unsigned i = 0; i < NUM_REQ; i++) cool_q[i] <= 10'd0;
      rr_ptr_q      <= '0;
      fire_gnt_q    <= '0;
      slot_launch_q <= '0;
      slot_owner_q  <= '0;
      slot_dir_q    <= '0;
      slot_x_q      <= '0;
      slot_y_q      <= '0;
    end else begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        slot_st_q[s] <= slot_st_d[s];
        if (do_grant && slot_idx == SlotW'(s)) begin
          slot_owner_q[2*s +: 2] <= 2'(gnt_idx);
          slot_dir_q[2*s +: 2]   <= req_dir[2*gnt_idx +: 2];
          slot_x_q[10*s +: 10]   <= req_x[10*gnt_idx +: 10];
          slot_y_q[10*s +: 10]   <= req_y[10*gnt_idx +: 10];
        end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) cool_q[i] <= cool_d[i];
      rr_ptr_q      <= rr_ptr_d;
      fire_gnt_q    <= fire_gnt_d;
      slot_launch_q <= slot_launch_d;
    end
  end

  // Busy is a pure decode of the registered slot state.
  always_comb begin
    slot_busy = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) slot_busy[s] = (slot_st_q[s] != StFree);
  end

  assign fire_gnt    = fire_gnt_q;
  assign slot_launch = slot_launch_q;
  assign slot_owner  = slot_owner_q;
  assign slot_dir    = slot_dir_q;
  assign slot_x      = slot_x_q;
  assign slot_y      = slot_y_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: a per-frame vector table plus
// hand-written sequences for arbitration, cooldown and async reset.
module tb_bullet_scheduler;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  fire_req = '0;
  logic [7:0]  req_dir;
  logic [39:0] req_x, req_y;
  logic [1:0]  slot_done = '0;
  logic [3:0]  fire_gnt;
  logic [1:0]  slot_launch, slot_busy;
  logic [3:0]  slot_owner, slot_dir;
  logic [19:0] slot_x, slot_y;

  int checks = 0;
  int failures = 0;

  bullet_scheduler dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .fire_req    (fire_req),
    .req_dir     (req_dir),
    .req_x       (req_x),
    .req_y       (req_y),
    .slot_done   (slot_done),
    .fire_gnt    (fire_gnt),
    .slot_launch (slot_launch),
    .slot_busy   (slot_busy),
    .slot_owner  (slot_owner),
    .slot_dir    (slot_dir),
    .slot_x      (slot_x),
    .slot_y      (slot_y)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  done;
    logic [9:0]  x0;
    logic [3:0]  gnt;
    logic [1:0]  launch;
    logic [1:0]  busy;
    logic [19:0] sx;
    logic [19:0] sy;
    logic [3:0]  sdir;
    logic [3:0]  own;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One frame edge, then settle before sampling.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_tanks(input logic [9:0] x0);
    req_dir = {2'b10, 2'b01, 2'b11, 2'b00};
    req_x   = {10'd600, 10'd200, 10'd100, x0};
    req_y   = {10'd10, 10'd300, 10'd50, 10'd400};
  endtask

  task automatic do_reset();
    Reset     = 1'b0;
    fire_req  = '0;
    slot_done = '0;
    step();
    step();
    Reset = 1'b1;
  endtask

  initial begin
    tbl[0] = '{4'b0001, 2'b00, 10'd320, 4'b0001, 2'b01, 2'b01,
               {10'd0, 10'd320}, {10'd0, 10'd400}, 4'b0000, 4'b0000};
    tbl[1] = '{4'b0000, 2'b00, 10'd5, 4'b0000, 2'b00, 2'b01,
               {10'd0, 10'd320}, {10'd0, 10'd400}, 4'b0000, 4'b0000};
    tbl[2] = '{4'b0010, 2'b10, 10'd5, 4'b0010, 2'b10, 2'b11,
               {10'd100, 10'd320}, {10'd50, 10'd400}, 4'b1100, 4'b0100};
    tbl[3] = '{4'b0000, 2'b10, 10'd5, 4'b0000, 2'b00, 2'b11,
               {10'd100, 10'd320}, {10'd50, 10'd400}, 4'b1100, 4'b0100};
    tbl[4] = '{4'b0100, 2'b00, 10'd5, 4'b0000, 2'b00, 2'b11,
               {10'd100, 10'd320}, {10'd50, 10'd400}, 4'b1100, 4'b0100};
    tbl[5] = '{4'b0100, 2'b01, 10'd5, 4'b0000, 2'b00, 2'b10,
               {10'd100, 10'd320}, {10'd50, 10'd400}, 4'b1100, 4'b0100};
    tbl[6] = '{4'b0100, 2'b00, 10'd5, 4'b0100, 2'b01, 2'b11,
               {10'd100, 10'd200}, {10'd50, 10'd300}, 4'b1101, 4'b0110};
    tbl[7] = '{4'b0000, 2'b11, 10'd5, 4'b0000, 2'b00, 2'b01,
               {10'd100, 10'd200}, {10'd50, 10'd300}, 4'b1101, 4'b0110};

    set_tanks(10'd320);
    do_reset();
    check("reset_gnt", 64'(fire_gnt), 64'd0);
    check("reset_launch", 64'(slot_launch), 64'd0);
    check("reset_busy", 64'(slot_busy), 64'd0);
    check("reset_payload", {slot_x, slot_y, slot_dir, slot_owner}, 64'd0);

    // Table: single launch, done ignored in FREE/LAUNCH, full slots, reuse.
    for (int r = 0; r < 8; r++) begin
      fire_req  = tbl[r].req;
      slot_done = tbl[r].done;
      set_tanks(tbl[r].x0);
      step();
      check($sformatf("tbl%0d_gnt", r), 64'(fire_gnt), 64'(tbl[r].gnt));
      check($sformatf("tbl%0d_launch", r), 64'(slot_launch), 64'(tbl[r].launch));
      check($sformatf("tbl%0d_busy", r), 64'(slot_busy), 64'(tbl[r].busy));
      check($sformatf("tbl%0d_x", r), 64'(slot_x), 64'(tbl[r].sx));
      check($sformatf("tbl%0d_y", r), 64'(slot_y), 64'(tbl[r].sy));
      check($sformatf("tbl%0d_dir", r), 64'(slot_dir), 64'(tbl[r].sdir));
      check($sformatf("tbl%0d_owner", r), 64'(slot_owner), 64'(tbl[r].own));
    end

    // All four tanks firing: 0 then 1, stall while full, then 2 after slot 0 frees.
    set_tanks(10'd320);
    do_reset();
    fire_req = 4'b1111;
    step();
    check("rr_first", 64'(fire_gnt), 64'b0001);
    step();
    check("rr_second", 64'(fire_gnt), 64'b0010);
    check("rr_second_launch", 64'(slot_launch), 64'b10);
    step();
    check("rr_full_a", 64'(fire_gnt), 64'd0);
    step();
    check("rr_full_b", 64'(fire_gnt), 64'd0);
    slot_done = 2'b01;
    step();
    check("rr_free_edge", 64'(fire_gnt), 64'd0);
    check("rr_free_busy", 64'(slot_busy), 64'b10);
    slot_done = 2'b00;
    step();
    check("rr_third", 64'(fire_gnt), 64'b0100);
    check("rr_third_launch", 64'(slot_launch), 64'b01);
    check("rr_third_owner", 64'(slot_owner[1:0]), 64'd2);

    // Cooldown: regrant only once 30 frames have elapsed since the grant.
    do_reset();
    fire_req = 4'b0001;
    step();
    check("cool_grant", 64'(fire_gnt), 64'b0001);
    for (int k = 1; k <= 31; k++) begin
      slot_done = (k == 5) ? 2'b01 : 2'b00;
      step();
      check($sformatf("cool_k%0d", k), 64'(fire_gnt), (k == 31) ? 64'b0001 : 64'd0);
    end
    slot_done = 2'b00;

    // Async reset during a LAUNCH cycle, then a fresh grant to tank 1.
    do_reset();
    fire_req = 4'b0001;
    step();
    check("ar_launch", 64'(slot_launch), 64'b01);
    #2;
    Reset = 1'b0;
    #1;
    check("ar_gnt", 64'(fire_gnt), 64'd0);
    check("ar_launch0", 64'(slot_launch), 64'd0);
    check("ar_busy", 64'(slot_busy), 64'd0);
    check("ar_payload", {slot_x, slot_y, slot_dir, slot_owner}, 64'd0);
    fire_req = 4'b0010;
    step();
    Reset = 1'b1;
    step();
    check("ar_regrant", 64'(fire_gnt), 64'b0010);
    check("ar_regrant_slot", 64'(slot_launch), 64'b01);
    check("ar_regrant_owner", 64'(slot_owner[1:0]), 64'd1);
    check("ar_regrant_x", 64'(slot_x[9:0]), 64'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
